// File: rtl/al4s3b_fpga_sdma_ctrl_if.sv
// -----------------------------------------------------------------------------
// al4s3b_fpga_sdma_ctrl_if
// Wishbone slave bus bundle for the SDMA control block.
//   WBs_ADR_i       word address (ADDRWIDTH bits)
//   WBs_CYC_i       cycle select
//   WBs_STB_i       strobe
//   WBs_WE_i        write enable
//   WBs_BYTE_STB_i  byte-lane enables
//   WBs_DAT_i       write data
//   WBs_DAT_o       read data
//   WBs_ACK_o       transfer acknowledge
// The master modport drives requests; the slave modport answers them.
// -----------------------------------------------------------------------------
interface al4s3b_fpga_sdma_ctrl_if #(
  parameter int ADDRWIDTH = 2
);
  logic [ADDRWIDTH-1:0] WBs_ADR_i;
  logic                 WBs_CYC_i;
  logic                 WBs_STB_i;
  logic                 WBs_WE_i;
  logic [3:0]           WBs_BYTE_STB_i;
  logic [31:0]          WBs_DAT_i;
  logic [31:0]          WBs_DAT_o;
  logic                 WBs_ACK_o;

  modport master (
    output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    input  WBs_DAT_o, WBs_ACK_o
  );

  modport slave (
    input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    output WBs_DAT_o, WBs_ACK_o
  );
endinterface

// File: rtl/al4s3b_fpga_sdma_ctrl.sv
// -----------------------------------------------------------------------------
// al4s3b_fpga_sdma_ctrl
// Register-programmed controller that requests SDMA bursts, counts completed
// bursts, guards each burst with a watchdog and raises level interrupts.
//
// Ports
//   WB_CLK        sole clock, rising edge
//   WB_RST        asynchronous active-high reset
//   wb            Wishbone slave bundle (see al4s3b_fpga_sdma_ctrl_if)
//   SDMA_Req_o    channel request (registered)
//   SDMA_Sreq_o   single request, always 0
//   SDMA_Active_i channel active, synchronous to WB_CLK
//   SDMA_Done_i   channel done, synchronous to WB_CLK (rising edge = event)
//   fDone_Intr_o  (DONE_STS & DONE_IE) | ERR_STS, registered
//   f_DMA_Intr_o  BURST_STS & BURST_IE, registered
//
// Register map (word address)
//   0 CTRL      [0] DMA_EN  [1] DONE_IE  [2] BURST_IE
//   1 STATUS    [0] DONE_STS W1C  [1] BURST_STS W1C  [2] ERR_STS W1C
//               [3] BUSY  [5:4] state code
//   2 BURST_CNT [7:0] remaining bursts, writes ignored while busy
//   3 DONE_CNT  [7:0] completed bursts, any write clears
// -----------------------------------------------------------------------------
module al4s3b_fpga_sdma_ctrl #(
  parameter logic [15:0] TIMEOUT   = 16'hFFFF,
  parameter int          ADDRWIDTH = 2
) (
  input  logic                          WB_CLK,
  input  logic                          WB_RST,
  al4s3b_fpga_sdma_ctrl_if.slave        wb,
  output logic                          SDMA_Req_o,
  output logic                          SDMA_Sreq_o,
  input  logic                          SDMA_Active_i,
  input  logic                          SDMA_Done_i,
  output logic                          fDone_Intr_o,
  output logic                          f_DMA_Intr_o
);

  localparam logic [ADDRWIDTH-1:0] ADR_CTRL   = ADDRWIDTH'(32'd0);
  localparam logic [ADDRWIDTH-1:0] ADR_STATUS = ADDRWIDTH'(32'd1);
  localparam logic [ADDRWIDTH-1:0] ADR_BCNT   = ADDRWIDTH'(32'd2);
  localparam logic [ADDRWIDTH-1:0] ADR_DCNT   = ADDRWIDTH'(32'd3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t      state_q;
  logic        ack_q;
  logic        dma_en_q;
  logic        done_ie_q;
  logic        burst_ie_q;
  logic        done_sts_q;
  logic        burst_sts_q;
  logic        err_sts_q;
  logic [7:0]  bcnt_q;
  logic [7:0]  dcnt_q;
  logic [15:0] wdt_q;
  logic        done_prev_q;
  logic        req_q;
  logic        fdone_intr_q;
  logic        fdma_intr_q;

  logic        bus_sel_s;
  logic        wr_s;
  logic        wr_ctrl_s;
  logic        wr_status_s;
  logic        wr_bcnt_s;
  logic        wr_dcnt_s;
  logic        dma_en_d;
  logic        w1c_done_s;
  logic        w1c_burst_s;
  logic        w1c_err_s;
  logic        done_evt_s;
  logic        wdt_hit_s;
  logic        busy_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  // Bus decode, write strobes, event detection and the combinational read mux.
  always_comb begin
    bus_sel_s = wb.WBs_CYC_i & wb.WBs_STB_i;
    // A write commits only on the edge that raises ACK, and every register
    // field lives in byte lane 0, so lane 0 alone gates the write.
    wr_s        = bus_sel_s & wb.WBs_WE_i & ~ack_q & wb.WBs_BYTE_STB_i[0];
    wr_ctrl_s   = wr_s & (wb.WBs_ADR_i == ADR_CTRL);
    wr_status_s = wr_s & (wb.WBs_ADR_i == ADR_STATUS);
    wr_bcnt_s   = wr_s & (wb.WBs_ADR_i == ADR_BCNT);
    wr_dcnt_s   = wr_s & (wb.WBs_ADR_i == ADR_DCNT);

    // DMA_EN as it will be after this edge, so an abort lands on the commit edge.
    if (wr_ctrl_s) begin
      dma_en_d = wb.WBs_DAT_i[0];
    end else begin
      dma_en_d = dma_en_q;
    end

    w1c_done_s  = wr_status_s & wb.WBs_DAT_i[0];
    w1c_burst_s = wr_status_s & wb.WBs_DAT_i[1];
    w1c_err_s   = wr_status_s & wb.WBs_DAT_i[2];

    done_evt_s = SDMA_Done_i & ~done_prev_q;
    wdt_hit_s  = (wdt_q == (TIMEOUT - 16'd1));
    busy_s     = (state_q != ST_IDLE);

    rd_data_s = 32'd0;
    case (wb.WBs_ADR_i)
      ADR_CTRL:   rd_data_s = {29'd0, burst_ie_q, done_ie_q, dma_en_q};
      ADR_STATUS: rd_data_s = {26'd0, state_q, busy_s, err_sts_q, burst_sts_q, done_sts_q};
      ADR_BCNT:   rd_data_s = {24'd0, bcnt_q};
      ADR_DCNT:   rd_data_s = {24'd0, dcnt_q};
      default:    rd_data_s = 32'd0;
    endcase
  end

  assign wb.WBs_DAT_o = rd_data_s;
  assign wb.WBs_ACK_o = ack_q;
  assign SDMA_Req_o   = req_q;
  assign SDMA_Sreq_o  = 1'b0;
  assign fDone_Intr_o = fdone_intr_q;
  assign f_DMA_Intr_o = fdma_intr_q;

  // Lanes and data bits that carry no register field.
  assign unused_s = ^{wb.WBs_DAT_i[31:8], wb.WBs_BYTE_STB_i[3:1]};

  // Register file, transfer FSM, watchdog and interrupt registers. Software
  // clears are applied first so later hardware sets on the same edge win.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      dma_en_q     <= 1'b0;
      done_ie_q    <= 1'b0;
      burst_ie_q   <= 1'b0;
      done_sts_q   <= 1'b0;
      burst_sts_q  <= 1'b0;
      err_sts_q    <= 1'b0;
      bcnt_q       <= 8'd0;
      dcnt_q       <= 8'd0;
      wdt_q        <= 16'd0;
      done_prev_q  <= 1'b0;
      req_q        <= 1'b0;
      fdone_intr_q <= 1'b0;
      fdma_intr_q  <= 1'b0;
    end else begin
      ack_q       <= bus_sel_s & ~ack_q;
      done_prev_q <= SDMA_Done_i;

      if (wr_ctrl_s) begin
        dma_en_q   <= wb.WBs_DAT_i[0];
        done_ie_q  <= wb.WBs_DAT_i[1];
        burst_ie_q <= wb.WBs_DAT_i[2];
      end

      if (w1c_done_s) begin
        done_sts_q <= 1'b0;
      end
      if (w1c_burst_s) begin
        burst_sts_q <= 1'b0;
      end
      if (w1c_err_s) begin
        err_sts_q <= 1'b0;
      end

      // The remaining-burst count is frozen against software while a burst runs.
      if (wr_bcnt_s && !busy_s) begin
        bcnt_q <= wb.WBs_DAT_i[7:0];
      end
      if (wr_dcnt_s) begin
        dcnt_q <= 8'd0;
      end

      fdone_intr_q <= (done_sts_q & done_ie_q) | err_sts_q;
      fdma_intr_q  <= burst_sts_q & burst_ie_q;

      case (state_q)
        ST_IDLE: begin
          req_q <= 1'b0;
          if (dma_en_q && (bcnt_q != 8'd0)) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            wdt_q   <= 16'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_REQ: begin
          if (SDMA_Active_i) begin
            state_q <= ST_ACTIVE;
            req_q   <= 1'b0;
            wdt_q   <= wdt_q + 16'd1;
          end else if (!dma_en_d) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end else if (wdt_hit_s) begin
            state_q   <= ST_ERR;
            req_q     <= 1'b0;
            err_sts_q <= 1'b1;
            bcnt_q    <= 8'd0;
          end else begin
            wdt_q <= wdt_q + 16'd1;
          end
        end

        // Clearing DMA_EN here deliberately does not abort the burst.
        ST_ACTIVE: begin
          req_q <= 1'b0;
          if (done_evt_s) begin
            state_q     <= ST_IDLE;
            dcnt_q      <= dcnt_q + 8'd1;
            burst_sts_q <= 1'b1;
            // Saturate at zero; 1 or 0 both leave the count empty.
            if (bcnt_q <= 8'd1) begin
              bcnt_q     <= 8'd0;
              done_sts_q <= 1'b1;
            end else begin
              bcnt_q <= bcnt_q - 8'd1;
            end
          end else if (wdt_hit_s) begin
            state_q   <= ST_ERR;
            err_sts_q <= 1'b1;
            bcnt_q    <= 8'd0;
          end else begin
            wdt_q <= wdt_q + 16'd1;
          end
        end

        // Held until software acknowledges the error by clearing ERR_STS.
        ST_ERR: begin
          req_q <= 1'b0;
          if (w1c_err_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ERR;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_al4s3b_fpga_sdma_ctrl.sv
module tb_al4s3b_fpga_sdma_ctrl;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_BCNT   = 2'd2;
  localparam logic [1:0] A_DCNT   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdma_req;
  logic sdma_sreq;
  logic sdma_active = 1'b0;
  logic sdma_done   = 1'b0;
  logic fdone_intr;
  logic fdma_intr;

  int n_vec = 0;
  int n_err = 0;

  logic req_prev = 1'b0;
  int   req_rises = 0;

  al4s3b_fpga_sdma_ctrl_if #(.ADDRWIDTH(2)) wb_if ();

  al4s3b_fpga_sdma_ctrl #(.TIMEOUT(16'd16), .ADDRWIDTH(2)) dut (
    .WB_CLK        (clk),
    .WB_RST        (rst),
    .wb            (wb_if),
    .SDMA_Req_o    (sdma_req),
    .SDMA_Sreq_o   (sdma_sreq),
    .SDMA_Active_i (sdma_active),
    .SDMA_Done_i   (sdma_done),
    .fDone_Intr_o  (fdone_intr),
    .f_DMA_Intr_o  (fdma_intr)
  );

  always #5 clk = ~clk;

  // Count rising edges of the request, sampled on the falling clock edge.
  always @(negedge clk) begin
    req_prev <= sdma_req;
    if (sdma_req && !req_prev) req_rises <= req_rises + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered and left on a falling edge.
  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] be);
    int n;
    wb_if.WBs_ADR_i      = adr;
    wb_if.WBs_DAT_i      = dat;
    wb_if.WBs_BYTE_STB_i = be;
    wb_if.WBs_WE_i       = 1'b1;
    wb_if.WBs_CYC_i      = 1'b1;
    wb_if.WBs_STB_i      = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_if.WBs_ACK_o && n < 4);
    if (!wb_if.WBs_ACK_o) check_vec("wr_ack_timeout", 32'd0, 32'd1);
    wb_if.WBs_CYC_i = 1'b0;
    wb_if.WBs_STB_i = 1'b0;
    wb_if.WBs_WE_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] dat);
    int n;
    wb_if.WBs_ADR_i      = adr;
    wb_if.WBs_BYTE_STB_i = 4'hF;
    wb_if.WBs_WE_i       = 1'b0;
    wb_if.WBs_CYC_i      = 1'b1;
    wb_if.WBs_STB_i      = 1'b1;
    dat = 32'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_if.WBs_ACK_o && n < 4);
    if (wb_if.WBs_ACK_o) dat = wb_if.WBs_DAT_o;
    else check_vec("rd_ack_timeout", 32'd0, 32'd1);
    wb_if.WBs_CYC_i = 1'b0;
    wb_if.WBs_STB_i = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    check_vec(tag, d, exp);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!sdma_req && n < 50) begin @(negedge clk); n++; end
    if (!sdma_req) check_vec("req_timeout", 32'd0, 32'd1);
  endtask

  // Channel model: Active two cycles after Req, Done pulsed five cycles later.
  task automatic do_burst();
    wait_req();
    repeat (2) @(negedge clk);
    sdma_active = 1'b1;
    repeat (5) @(negedge clk);
    sdma_done = 1'b1;
    @(negedge clk);
    sdma_done   = 1'b0;
    sdma_active = 1'b0;
  endtask

  initial begin
    int base;
    wb_if.WBs_ADR_i      = 2'd0;
    wb_if.WBs_DAT_i      = 32'd0;
    wb_if.WBs_BYTE_STB_i = 4'h0;
    wb_if.WBs_WE_i       = 1'b0;
    wb_if.WBs_CYC_i      = 1'b0;
    wb_if.WBs_STB_i      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_vec("rst_req",   {31'd0, sdma_req},   32'd0);
    check_vec("rst_sreq",  {31'd0, sdma_sreq},  32'd0);
    check_vec("rst_fdone", {31'd0, fdone_intr}, 32'd0);
    check_vec("rst_fdma",  {31'd0, fdma_intr},  32'd0);
    rd_check("rst_ctrl",   A_CTRL,   32'd0);
    rd_check("rst_status", A_STATUS, 32'd0);
    rd_check("rst_bcnt",   A_BCNT,   32'd0);
    rd_check("rst_dcnt",   A_DCNT,   32'd0);

    // Three full bursts
    base = req_rises;
    wb_write(A_BCNT, 32'd3, 4'h1);
    wb_write(A_CTRL, 32'h7, 4'h1);
    repeat (3) do_burst();
    repeat (10) @(negedge clk);
    check_vec("burst3_req_pulses", req_rises - base, 32'd3);
    check_vec("burst3_req_low", {31'd0, sdma_req}, 32'd0);
    rd_check("burst3_dcnt",   A_DCNT,   32'd3);
    rd_check("burst3_bcnt",   A_BCNT,   32'd0);
    rd_check("burst3_status", A_STATUS, 32'h03);
    check_vec("burst3_fdone", {31'd0, fdone_intr}, 32'd1);
    check_vec("burst3_fdma",  {31'd0, fdma_intr},  32'd1);

    // Abort from REQ
    wb_write(A_STATUS, 32'h7, 4'h1);
    wb_write(A_CTRL,   32'h0, 4'h1);
    wb_write(A_BCNT,   32'd2, 4'h1);
    wb_write(A_CTRL,   32'h1, 4'h1);
    wait_req();
    wb_write(A_CTRL, 32'h0, 4'h1);
    check_vec("abort_req", {31'd0, sdma_req}, 32'd0);
    rd_check("abort_status", A_STATUS, 32'h00);
    rd_check("abort_bcnt",   A_BCNT,   32'd2);
    rd_check("abort_dcnt",   A_DCNT,   32'd3);

    // Watchdog: REQ lasts exactly 16 cycles
    wb_write(A_BCNT, 32'd4, 4'h1);
    wb_write(A_CTRL, 32'h1, 4'h1);
    wait_req();
    repeat (15) @(negedge clk);
    check_vec("wdt_req_c15", {31'd0, sdma_req}, 32'd1);
    @(negedge clk);
    check_vec("wdt_req_c16", {31'd0, sdma_req}, 32'd0);
    rd_check("wdt_status", A_STATUS, 32'h3C);
    rd_check("wdt_bcnt",   A_BCNT,   32'd0);
    check_vec("wdt_fdone", {31'd0, fdone_intr}, 32'd1);
    wb_write(A_STATUS, 32'h4, 4'h1);
    rd_check("wdt_clr_status", A_STATUS, 32'h00);
    repeat (2) @(negedge clk);
    check_vec("wdt_clr_fdone", {31'd0, fdone_intr}, 32'd0);

    // W1C of BURST_STS on the same edge as a Done event
    wb_write(A_BCNT, 32'd1, 4'h1);
    wait_req();
    repeat (2) @(negedge clk);
    sdma_active = 1'b1;
    repeat (3) @(negedge clk);
    sdma_done = 1'b1;
    wb_write(A_STATUS, 32'h2, 4'h1);
    sdma_done   = 1'b0;
    sdma_active = 1'b0;
    rd_check("setwins_status", A_STATUS, 32'h03);
    rd_check("setwins_dcnt",   A_DCNT,   32'd4);

    // BURST_CNT write while busy is ignored
    wb_write(A_STATUS, 32'h7, 4'h1);
    wb_write(A_BCNT, 32'd2, 4'h1);
    wait_req();
    wb_write(A_BCNT, 32'd5, 4'h1);
    sdma_active = 1'b1;
    @(negedge clk);
    sdma_done = 1'b1;
    @(negedge clk);
    sdma_done   = 1'b0;
    sdma_active = 1'b0;
    rd_check("busywr_bcnt_mid", A_BCNT, 32'd1);
    do_burst();
    repeat (3) @(negedge clk);
    rd_check("busywr_bcnt_end", A_BCNT, 32'd0);

    // Writes with no byte lane enabled change nothing; DONE_CNT write clears
    wb_write(A_BCNT, 32'd7, 4'h0);
    rd_check("nobe_bcnt", A_BCNT, 32'd0);
    wb_write(A_CTRL, 32'h0, 4'h0);
    rd_check("nobe_ctrl", A_CTRL, 32'h1);
    rd_check("dcnt_before_clr", A_DCNT, 32'd6);
    wb_write(A_DCNT, 32'hAB, 4'h1);
    rd_check("dcnt_after_clr", A_DCNT, 32'd0);

    // Asynchronous reset during ACTIVE
    wb_write(A_CTRL, 32'h7, 4'h1);
    wb_write(A_BCNT, 32'd3, 4'h1);
    wait_req();
    repeat (2) @(negedge clk);
    sdma_active = 1'b1;
    repeat (3) @(negedge clk);
    wb_if.WBs_ADR_i = A_STATUS;
    #1;
    check_vec("prerst_dat",   wb_if.WBs_DAT_o, 32'h2B);
    check_vec("prerst_fdone", {31'd0, fdone_intr}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_vec("async_rst_req",   {31'd0, sdma_req},   32'd0);
    check_vec("async_rst_fdone", {31'd0, fdone_intr}, 32'd0);
    check_vec("async_rst_fdma",  {31'd0, fdma_intr},  32'd0);
    check_vec("async_rst_ack",   {31'd0, wb_if.WBs_ACK_o}, 32'd0);
    check_vec("async_rst_dat",   wb_if.WBs_DAT_o, 32'd0);
    sdma_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_vec("postrst_req", {31'd0, sdma_req}, 32'd0);
    rd_check("postrst_ctrl", A_CTRL, 32'd0);
    rd_check("postrst_bcnt", A_BCNT, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
